gate_meter: RTL and testbench
=============================

Name: gate_meter

Overview:
- Receive-side counterpart of the team's periodic gate/pulse generators.
- Samples an asynchronous gate waveform, measures high time, low time and period in clk cycles, and reports each complete period with a one-cycle valid strobe.
- Used on the capture side of test benches and boards to check generator output timing (e.g. high 3 / low 20 / period 23 cycles).

Parameters:
- CNT_W, 28, width of all length counters and result ports
- SYNC_STAGES, 2, input synchroniser depth (allowed range 2..3)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  measurement enable; low forces IDLE
- gate_in  input  1  asynchronous gate waveform under measurement
- high_len  output  CNT_W  cycles gate was high in last complete period
- low_len  output  CNT_W  cycles gate was low in last complete period
- period  output  CNT_W  high_len + low_len
- meas_valid  output  1  one-cycle strobe; results updated this cycle
- timeout  output  1  one-cycle strobe; a counter saturated and the measurement was discarded
- meas_cnt  output  16  number of valid measurements since reset, wraps at 16'hFFFF -> 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: all outputs 0, synchroniser flops 0, state IDLE.
- Synchroniser: gate_in passes SYNC_STAGES flops to give gate_s. gate_d is gate_s delayed one cycle.
- Edge detection:
  - rise = gate_s & ~gate_d
  - fall = ~gate_s & gate_d
  - A rise and a fall never occur in the same cycle.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: counters cleared. en=1 -> ARM.
  - ARM: discards any partial pulse present at enable time. rise -> HIGH with hcnt<=1.
  - HIGH: hcnt++ each cycle. fall -> LOW with lcnt<=1.
  - LOW: lcnt++ each cycle. rise -> capture results (see below), then HIGH with hcnt<=1.
- Capture on rise in LOW:
  - high_len<=hcnt, low_len<=lcnt, period<=hcnt+lcnt.
  - meas_valid<=1 for exactly one cycle, in the cycle after the rise cycle.
  - meas_cnt increments.
  - Consecutive periods are measured back to back with no cycle lost.
- Latency: gate_in edge to meas_valid is SYNC_STAGES + 2 cycles.
- Period arithmetic: if hcnt+lcnt overflows CNT_W, period saturates at all-ones; high_len and low_len are still captured.
- Timeout: if hcnt or lcnt reaches 2^CNT_W-1 (stuck-at gate):
  - timeout pulses for one cycle;
  - FSM -> ARM;
  - counters cleared;
  - result outputs hold their previous values.
- en deasserted in any state: -> IDLE next cycle, the partial measurement is discarded, results and meas_cnt hold, no strobes are issued.
- rst mid-measurement: everything returns to reset values next cycle; no strobe is issued.
- Minimum pulse: a 1-cycle high or low (after synchronisation) is measured as length 1.
- Result ports are stable between meas_valid strobes.

Decomposition:
- Shared package (gate_pkg): state enum (IDLE, ARM, HIGH, LOW) and the default CNT_W constant. Generator blocks reuse the same constant.
- One natural sub-module: gate_sync_edge, containing the SYNC_STAGES synchroniser plus rise/fall detection and exposing gate_s, rise and fall.
- Top level holds the FSM, counters and capture registers.

Test Plan:
- Periodic gate, high 3 / low 20 cycles, en=1: first meas_valid after the first full period. Every following period gives high_len=3, low_len=20, period=23, with meas_valid spaced exactly 23 cycles apart. meas_cnt increments by 1 per strobe.
- en raised while gate_in is mid-high: the partial pulse is ignored. The first reported result is a full period (3/20/23), never a truncated high.
- gate_in held high with CNT_W=8: timeout pulses once when hcnt reaches 255, with no meas_valid. Outputs keep their prior values. After gate_in resumes the 3/20 pattern, measurements are valid again.
- 1-cycle high pulses every 5 cycles: high_len=1, low_len=4, period=5 on every strobe.
- rst asserted mid-LOW, then released with the 3/20 pattern running: all outputs 0 during reset. After release, the first valid result is 3/20/23 and meas_cnt=1.
- en dropped mid-HIGH for 10 cycles, then re-raised: no strobe during the gap. Results hold their last values. Measurement resumes through ARM, with a correct 3/20/23.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate generator/meter family.
package gate_pkg;

  localparam int GATE_CNT_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } gate_state_e;

endpackage

// File: rtl/gate_sync_edge.sv
// Synchronises an asynchronous gate and produces registered rise/fall strobes,
// with a level output aligned to those strobes.
module gate_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_gate,
  output logic o_gate_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_gate_d;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_gate_s;

  assign w_gate_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_gate_d <= 1'b0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_gate};
      r_gate_d <= w_gate_s;
      // Strobes are registered so the FSM sees a clean, glitch-free edge.
      r_level  <= w_gate_s;
      r_rise   <= w_gate_s & ~r_gate_d;
      r_fall   <= ~w_gate_s & r_gate_d;
    end
  end

  assign o_gate_s = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/gate_meter.sv
// Measures high time, low time and period of a gate waveform in clk cycles,
// reporting each complete period with a one-cycle strobe.
module gate_meter
  import gate_pkg::*;
#(
  parameter int CNT_W       = GATE_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             gate_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             timeout,
  output logic [15:0]      meas_cnt
);

  // A counter holding this value cannot advance without reaching all-ones.
  localparam logic [CNT_W-1:0] LAST_LEN = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic w_gate_s, w_rise, w_fall;

  gate_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_gate   (gate_in),
    .o_gate_s (w_gate_s),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  gate_state_e      r_state;
  logic [CNT_W-1:0] r_hcnt, r_lcnt;
  logic [CNT_W-1:0] r_high_len, r_low_len, r_period;
  logic             r_meas_valid, r_timeout;
  logic [15:0]      r_meas_cnt;

  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_period;

  assign w_sum    = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_period = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_meas_cnt   <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_hcnt  <= '0;
        r_lcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_hcnt  <= '0;
            r_lcnt  <= '0;
            r_state <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_hcnt  <= ONE;
              r_lcnt  <= '0;
              r_state <= HIGH;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_lcnt  <= ONE;
              r_state <= LOW;
            end else if (r_hcnt == LAST_LEN) begin
              r_timeout <= 1'b1;
              r_hcnt    <= '0;
              r_lcnt    <= '0;
              r_state   <= ARM;
            end else begin
              r_hcnt <= r_hcnt + ONE;
            end
          end
          LOW: begin
            if (w_rise) begin
              // The rise that closes this period also opens the next one.
              r_high_len   <= r_hcnt;
              r_low_len    <= r_lcnt;
              r_period     <= w_period;
              r_meas_valid <= 1'b1;
              r_meas_cnt   <= r_meas_cnt + 16'd1;
              r_hcnt       <= ONE;
              r_lcnt       <= '0;
              r_state      <= HIGH;
            end else if (r_lcnt == LAST_LEN) begin
              r_timeout <= 1'b1;
              r_hcnt    <= '0;
              r_lcnt    <= '0;
              r_state   <= ARM;
            end else begin
              r_lcnt <= r_lcnt + ONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_rise && w_fall) && (!w_rise || w_gate_s) && (!w_fall || !w_gate_s));

  assign high_len   = r_high_len;
  assign low_len    = r_low_len;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign meas_cnt   = r_meas_cnt;

endmodule

// File: tb/tb_gate_meter.sv
// Randomised scoreboard bench for gate_meter: the driver predicts results from
// the pulse run lengths it drives; a monitor checks every strobe against them.
module tb_gate_meter;

  localparam int W       = 8;
  localparam int S       = 2;
  localparam int MAX_LEN = (1 << W) - 2;  // longest run measured without timeout
  localparam int ALL1    = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, en, gate_in;
  logic [W-1:0] high_len, low_len, period;
  logic         meas_valid, timeout;
  logic [15:0]  meas_cnt;

  always #5 clk = ~clk;

  gate_meter #(
    .CNT_W       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .gate_in    (gate_in),
    .high_len   (high_len),
    .low_len    (low_len),
    .period     (period),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .meas_cnt   (meas_cnt)
  );

  typedef struct {
    bit tmo;
    int h;
    int l;
    int p;
    int cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_last_h, m_last_l, m_last_p, m_cnt;
  int m_prev_h, m_prev_l;
  bit m_started, m_en;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input int h, input int l, input int p, input int c);
    check({tag, "_high_len"}, int'(high_len), h);
    check({tag, "_low_len"},  int'(low_len),  l);
    check({tag, "_period"},   int'(period),   p);
    check({tag, "_meas_cnt"}, int'(meas_cnt), c);
  endtask

  task automatic push_meas();
    exp_t e;
    m_last_h = m_prev_h;
    m_last_l = m_prev_l;
    m_last_p = (m_prev_h + m_prev_l > ALL1) ? ALL1 : m_prev_h + m_prev_l;
    m_cnt    = (m_cnt + 1) & 16'hFFFF;
    e = '{tmo: 1'b0, h: m_last_h, l: m_last_l, p: m_last_p, cnt: m_cnt};
    q.push_back(e);
  endtask

  task automatic push_tmo();
    exp_t e;
    e = '{tmo: 1'b1, h: m_last_h, l: m_last_l, p: m_last_p, cnt: m_cnt};
    q.push_back(e);
  endtask

  // ev: 0 plain, 1 raise en mid-high, 2 drop en mid-high for 10 cycles, 3 reset mid-low
  task automatic pulse(input int h, input int l, input int ev);
    if (m_en && m_started) push_meas();
    m_started = 1'b0;
    if (m_en && ev != 1 && ev != 2) begin
      if (h > MAX_LEN || l > MAX_LEN) push_tmo();
      else begin
        m_started = 1'b1;
        m_prev_h  = h;
        m_prev_l  = l;
      end
    end
    gate_in = 1'b1;
    if (ev == 1) begin
      repeat (5) tick();
      en = 1'b1;
      repeat (h - 5) tick();
    end else if (ev == 2) begin
      repeat (5) tick();
      en = 1'b0;
      repeat (10) tick();
      check_outputs("en_gap_hold", m_last_h, m_last_l, m_last_p, m_cnt);
      en = 1'b1;
      repeat (h - 15) tick();
    end else begin
      repeat (h) tick();
    end
    if (ev == 1 || ev == 2) m_en = 1'b1;
    gate_in = 1'b0;
    if (ev == 3) begin
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_outputs("mid_reset", 0, 0, 0, 0);
      check("mid_reset_strobes", int'(meas_valid) + int'(timeout), 0);
      repeat (2) tick();
      rst = 1'b0;
      m_cnt = 0; m_last_h = 0; m_last_l = 0; m_last_p = 0;
      m_started = 1'b0;
      repeat (l - 13) tick();
    end else begin
      repeat (l) tick();
    end
  endtask

  // Monitor: every strobe must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (meas_valid || timeout)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual valid=%0b timeout=%0b required none at %0t",
                   meas_valid, timeout, $time);
        end else begin
          e = q.pop_front();
          check("strobe_timeout", int'(timeout), int'(e.tmo));
          check("strobe_valid", int'(meas_valid), int'(!e.tmo));
          check_outputs(e.tmo ? "timeout_hold" : "meas", e.h, e.l, e.p, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual running required finished at %0t", $time);
    $fatal(1);
  end

  initial begin
    int h, l;
    rst = 1'b1; en = 1'b0; gate_in = 1'b0;
    m_cnt = 0; m_last_h = 0; m_last_l = 0; m_last_p = 0;
    m_prev_h = 0; m_prev_l = 0; m_started = 1'b0; m_en = 1'b0;
    repeat (3) tick();
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_strobes", int'(meas_valid) + int'(timeout), 0);
    rst = 1'b0;
    repeat (4) tick();

    pulse(3, 20, 0);            // disabled: ignored
    pulse(12, 20, 1);           // en raised mid-high: partial pulse discarded
    repeat (6) pulse(3, 20, 0);
    repeat (6) pulse(1, 4, 0);  // minimum high pulse
    pulse(4, 1, 0);             // minimum low pulse
    pulse(300, 20, 0);          // stuck high -> timeout
    repeat (3) pulse(3, 20, 0);
    pulse(MAX_LEN, MAX_LEN, 0); // longest measurable, period saturates
    pulse(MAX_LEN + 1, 5, 0);   // one past the limit in high
    pulse(3, 20, 0);
    pulse(5, MAX_LEN + 1, 0);   // one past the limit in low
    pulse(3, 20, 0);
    pulse(200, 100, 0);         // period overflow
    pulse(200, 55, 0);          // period exactly all-ones
    pulse(3, 20, 0);
    pulse(3, 20, 3);            // reset mid-low
    repeat (3) pulse(3, 20, 0);
    pulse(25, 20, 2);           // en dropped mid-high
    repeat (3) pulse(3, 20, 0);

    for (int i = 0; i < 120; i++) begin
      h = $urandom_range(1, 30);
      l = $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) h = $urandom_range(MAX_LEN - 10, MAX_LEN + 10);
      if ($urandom_range(0, 19) == 0) l = $urandom_range(MAX_LEN - 10, MAX_LEN + 10);
      pulse(h, l, 0);
    end

    gate_in = 1'b0;
    repeat (S + 8) tick();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
